// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   UART receiver. The frame is 8N1 and LSB first. Rx_in is oversampled with
//   the system clock, and every bit is sampled at its middle. The middle is
//   found by timing half a bit period from the start-bit falling edge.
//   Each good byte appears on data_out together with a one-cycle data_valid
//   strobe. A stop bit that is sampled low gives a one-cycle frame_err pulse
//   instead.
//
//   Optional feature, macro RX_PARITY_EN:
//     defined   -> the frame is 8E1. A parity bit follows the data bits, and
//                  a parity mismatch gives a one-cycle parity_err pulse
//                  instead of data_valid.
//     undefined -> the frame is 8N1 and parity_err is tied low.
//
// Parameters
//   Fclk        system clock frequency in Hz
//   Fuart       baud rate in bit/s; Fclk/Fuart must be at least 4
//
// Ports
//   clk_Rx      in   system clock; all logic runs on its rising edge
//   reset       in   asynchronous, active-high reset
//   Rx_in       in   serial line; idles high; asynchronous to clk_Rx
//   data_out    out  [7:0] last good byte; holds until the next good byte
//   data_valid  out  one-cycle pulse in the cycle data_out is updated
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   parity_err  out  one-cycle pulse on a parity mismatch (RX_PARITY_EN)
//   busy        out  high from start-edge detection until the FSM is IDLE
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int Fclk  = 50000000,
  parameter int Fuart = 9600
) (
  input  logic       clk_Rx,
  input  logic       reset,
  input  logic       Rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int divider = Fclk / Fuart;
  localparam logic [24:0] HALF_LAST = 25'(divider / 2 - 1);
  localparam logic [24:0] BIT_LAST  = 25'(divider - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    PARITY_BIT,
    STOP_BIT,
    WAIT_IDLE
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        rx_m;
  logic        rx_s;
  logic        rx_d;
  logic [24:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        fall_edge;
  logic        half_done;
  logic        bit_done;
  logic        valid_set;
  logic        frame_set;

  assign fall_edge = rx_d & ~rx_s;
  assign half_done = (cnt == HALF_LAST);
  assign bit_done  = (cnt == BIT_LAST);

`ifdef RX_PARITY_EN
  logic parity_bit;
  logic good_parity;
  logic parity_set;

  // Even parity: the data bits and the parity bit together must XOR to 0.
  assign good_parity = ~^{shreg, parity_bit};
`endif

  // Two-flop synchronizer, plus one extra delayed copy for edge detection.
  // The flops reset to the idle (high) line level, so leaving reset does not
  // look like a start edge.
  always_ff @(posedge clk_Rx or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= Rx_in;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_Rx or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic. A start edge is looked for only in IDLE, so a
  // falling edge in the middle of a frame is ignored.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (fall_edge) next_state = START_BIT;
      end
      START_BIT: begin
        // If the line is high again at mid start bit, the edge was a glitch.
        if (half_done) next_state = rx_s ? IDLE : DATA_BIT;
      end
      DATA_BIT: begin
        if (bit_done && bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
          next_state = PARITY_BIT;
`else
          next_state = STOP_BIT;
`endif
        end
      end
      PARITY_BIT: begin
        if (bit_done) next_state = STOP_BIT;
      end
      STOP_BIT: begin
        // A low stop bit may be a break, so wait for the line to go idle.
        if (bit_done) next_state = rx_s ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (rx_s) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs. The end-of-frame results are decoded here and registered
  // below. This is what makes the strobes appear one cycle after the sample
  // taken in the middle of the stop bit.
  always_comb begin
    busy      = (state != IDLE);
    valid_set = 1'b0;
    frame_set = 1'b0;
`ifdef RX_PARITY_EN
    parity_set = 1'b0;
`endif
    if (state == STOP_BIT && bit_done) begin
      frame_set = ~rx_s;
`ifdef RX_PARITY_EN
      valid_set  = rx_s & good_parity;
      parity_set = rx_s & ~good_parity;
`else
      valid_set  = rx_s;
`endif
    end
  end

  // Bit timing, data shifting, and the registered result strobes.
  // - The start bit counts only half a period. This puts every later sample
  //   in the middle of its bit.
  // - data_out changes only on a good frame.
  always_ff @(posedge clk_Rx or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, WAIT_IDLE: cnt <= '0;
        START_BIT:       cnt <= half_done ? '0 : cnt + 25'd1;
        default:         cnt <= bit_done  ? '0 : cnt + 25'd1;
      endcase

      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA_BIT && bit_done) begin
        shreg[bit_cnt] <= rx_s;
        bit_cnt        <= bit_cnt + 3'd1;
      end

`ifdef RX_PARITY_EN
      if (state == PARITY_BIT && bit_done) parity_bit <= rx_s;
      parity_err <= parity_set;
`endif

      data_valid <= valid_set;
      frame_err  <= frame_set;
      if (valid_set) data_out <= shreg;
    end
  end

`ifndef RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
